pipe_skid_reg: RTL
==================

// Module: pipe_skid_reg
// PURPOSE
// - Parametrised pipeline register with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
// - Sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces bare enabled registers.
// - Provides stall back-pressure, bubble insertion on flush, and full throughput with no combinational ready path.
// PARAMETERS
// - WIDTH        64   payload width in bits (>=1)
// - RESET_VALUE  '0   value loaded into both data entries on reset and on flush
// PORTS
// - clk        in   1      rising-edge clock
// - reset      in   1      asynchronous, active-low reset (asserted when 0)
// - flush      in   1      synchronous squash: discards all held and incoming data
// - in_valid   in   1      upstream has data on in_data
// - in_ready   out  1      block accepts in_data this cycle (registered)
// - in_data    in   WIDTH  upstream payload
// - out_valid  out  1      out_data holds a valid entry
// - out_ready  in   1      downstream consumes out_data this cycle
// - out_data   out  WIDTH  downstream payload, driven directly from the main entry
// - occupancy  out  2      number of valid entries (0..2)
// BEHAVIOUR
// - Handshake events: accept = in_valid & in_ready; consume = out_valid & out_ready.
// - Data only changes on accept/consume/flush/reset, so held entries stay stable under stall.
// - Reset (reset==0, async):
//   - state=EMPTY, out_valid=0, occupancy=0, in_ready=0;
//   - main and skid entries = RESET_VALUE.
//   - in_ready rises on the first clk edge after reset returns to 1.
//   - Reset mid-transfer drops all data; nothing is accepted while reset is asserted.
// - State machine (state reg; out_valid=(state!=EMPTY); occupancy=state encoding):
//   - EMPTY:
//     - accept -> main<=in_data, ONE.
//     - else stay.
//   - ONE:
//     - accept & consume -> main<=in_data, stay ONE.
//     - accept & !consume -> skid<=in_data, TWO.
//     - !accept & consume -> EMPTY.
//     - neither -> hold.
//   - TWO (in_ready=0, so accept is impossible):
//     - consume -> main<=skid, ONE.
//     - else hold.
// - in_ready is a flop: next value = (next_state != TWO). It never depends combinationally on out_ready.
// - Latency: in->out is 1 cycle from EMPTY. Throughput is 1 word/cycle with out_ready held high.
// - Flush:
//   - Highest priority; overrides accept and consume.
//   - Next state=EMPTY; main and skid <= RESET_VALUE; in_ready<=1.
//   - A word presented in the flush cycle is dropped, even if in_ready=1.
//   - A consume in the flush cycle is still seen downstream (its own handshake), but the entry is cleared.
// - Simultaneous flush & reset: reset wins (async).
// - Widths: payload is copied unmodified; no arithmetic.
// - Ordering: words exit in acceptance order; none duplicated or lost except by flush/reset.
// STRUCTURE
// - Package pipe_pkg:
//   - typedef enum logic [1:0] {PS_EMPTY=2'd0, PS_ONE=2'd1, PS_TWO=2'd2} pipe_state_t;
//   - the value 2'd3 is illegal and decodes to PS_EMPTY.
// - Sub-module en_reg #(WIDTH, RESET_VALUE):
//   - enabled register, async active-low reset;
//   - 2:1 hold/load mux per bit feeding a flop.
//   - Instantiated twice, for main and skid.
// - Top level holds the state FSM, the in_ready flop, and the mux selecting main's load source (in_data vs skid).
// TESTING
// - Reset:
//   - Hold reset=0 for 2 cycles, with in_valid=1 and in_data=64'hAAAA_AAAA_AAAA_AAAA.
//   - Required: out_valid=0, in_ready=0, occupancy=0, out_data=0 throughout.
//   - Required: in_ready=1 one edge after release.
// - Pass-through:
//   - Stream 64'h1, 64'h2, 64'h3 with out_ready=1.
//   - Required: each appears on out_data one cycle after accept; occupancy stays 1; in_ready stays 1.
// - Stall/skid:
//   - Set out_ready=0, then accept 64'h12345678_ABCDEF01 and 64'hDEADBEEF_CAFEFADE.
//   - Required: occupancy=2, in_ready=0 on the next edge, out_data=64'h12345678_ABCDEF01 held stable.
//   - Then raise out_ready: the two words exit in order over 2 cycles, and in_ready returns to 1.
// - Flush:
//   - From TWO, assert flush for 1 cycle while in_valid=1 with 64'hFFFF_FFFF_FFFF_FFFF.
//   - Required next cycle: out_valid=0, occupancy=0, out_data=0, in_ready=1, and the presented word never appears.
// - Async reset mid-stream:
//   - Drop reset between clock edges while in state ONE.
//   - Required: out_valid falls immediately (no edge); outputs match reset values.
// - Random:
//   - Random in_valid/out_ready for 10k cycles against a scoreboard queue.
//   - Required: in-order, lossless delivery; in_ready never 1 when occupancy=2.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the skid-buffered pipeline register.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    // The unused encoding 2'd3 is treated as empty so a corrupted state drains cleanly.
    function automatic pipe_state_t decode_state(input logic [1:0] raw);
        pipe_state_t s;
        case (raw)
            2'd1:    s = PS_ONE;
            2'd2:    s = PS_TWO;
            default: s = PS_EMPTY;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Upstream/downstream valid-ready channel of the pipeline register.
interface pipe_skid_reg_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_skid_reg_en_reg.sv
// Enabled register with asynchronous active-low reset; holds its value unless en_i is set.
module en_reg #(
    parameter int               WIDTH       = 64,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign data_d = en_i ? d_i : data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= RESET_VALUE;
        else        data_q <= data_d;
    end

    assign q_o = data_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// in_ready is registered, so there is no combinational path from out_ready back upstream.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 64,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    pipe_skid_reg_if.slave  bus
);
    pipe_state_t      state_q, state_d, state_cur;
    logic             in_ready_q, in_ready_d;
    logic             accept, consume;
    logic             main_en, skid_en, main_from_skid;
    logic [WIDTH-1:0] main_q, skid_q, main_d, skid_d;

    assign state_cur = decode_state(state_q);
    assign accept    = bus.in_valid & in_ready_q;
    assign consume   = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d        = state_cur;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = PS_EMPTY;
            main_en = 1'b1;
            skid_en = 1'b1;
        end else begin
            case (state_cur)
                PS_EMPTY: begin
                    if (accept) begin
                        main_en = 1'b1;
                        state_d = PS_ONE;
                    end
                end
                PS_ONE: begin
                    if (accept && consume) begin
                        main_en = 1'b1;
                    end else if (accept) begin
                        skid_en = 1'b1;
                        state_d = PS_TWO;
                    end else if (consume) begin
                        state_d = PS_EMPTY;
                    end
                end
                PS_TWO: begin
                    if (consume) begin
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = PS_ONE;
                    end
                end
                default: state_d = PS_EMPTY;
            endcase
        end
        in_ready_d = (state_d != PS_TWO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PS_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign main_d = flush ? RESET_VALUE : (main_from_skid ? skid_q : bus.in_data);
    assign skid_d = flush ? RESET_VALUE : bus.in_data;

    en_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
        .clk   (clk),
        .rst_n (reset),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    en_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
        .clk   (clk),
        .rst_n (reset),
        .en_i  (skid_en),
        .d_i   (skid_d),
        .q_o   (skid_q)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_cur != PS_EMPTY);
    assign bus.occupancy = state_cur;
    assign bus.out_data  = main_q;
endmodule
